// File: rtl/regbank_board_ctrl.sv
// ============================================================================
// Module   : regbank_board_ctrl
// Brief    : Single-clock board controller: tick generator, debounced buttons,
//            2R/1W register bank, sequential clear engine and LED display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_board_ctrl #(
    parameter int W         = 4,
    parameter int A         = 4,
    parameter int DIV_COUNT = 100_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 8,
    parameter int ZERO_REG  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3*A+W-1:0]       sw,
    input  logic                   btn_we,
    input  logic                   btn_clr,
    output logic [2*W+CNT_W-1:0]   led,
    output logic                   busy,
    output logic                   tick
);

    localparam int c_NREG = 2**A;
    localparam int c_CW   = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam int c_DBW  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CW-1:0]  c_TICK_MAX = c_CW'(DIV_COUNT - 1);
    localparam logic [c_DBW-1:0] c_DB_MAX   = c_DBW'(DB_CYCLES - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CLEAR = 1'b1;

    logic [A-1:0]       w_addr_rs1;
    logic [A-1:0]       w_addr_rs2;
    logic [A-1:0]       w_addr_rd;
    logic [W-1:0]       w_data_in;
    logic [1:0]         w_btn_raw;
    logic [1:0]         w_pulse;
    logic               w_we_p;
    logic               w_clr_p;
    logic               w_tick;
    logic               w_wr_ok;
    logic               w_busy;
    logic               w_clr_we;
    logic [W-1:0]       w_rs1;
    logic [W-1:0]       w_rs2;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [A-1:0]       r_idx;
    logic [c_CW-1:0]    r_tick_cnt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [2*W+CNT_W-1:0] r_led;
    logic [W-1:0]       r_bank [0:c_NREG-1];

    assign {w_addr_rs1, w_addr_rs2, w_addr_rd, w_data_in} = sw;
    assign w_btn_raw = {btn_clr, btn_we};
    assign w_we_p    = w_pulse[0];
    assign w_clr_p   = w_pulse[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_TICK_MAX) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_CW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_MAX);
    assign tick   = w_tick;

    // Level only moves after DB_CYCLES consecutive disagreeing samples.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic             r_sync1;
        logic             r_sync2;
        logic             r_lvl;
        logic             r_lvl_d;
        logic [c_DBW-1:0] r_db_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_lvl    <= 1'b0;
                r_lvl_d  <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync1 <= w_btn_raw[gi];
                r_sync2 <= r_sync1;
                r_lvl_d <= r_lvl;
                if (r_sync2 != r_lvl) begin
                    if (r_db_cnt == c_DB_MAX) begin
                        r_lvl    <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_DBW'(1);
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end
        end

        assign w_pulse[gi] = r_lvl & ~r_lvl_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_clr_p)   w_state_nxt = c_CLEAR;
            c_CLEAR: if (&r_idx)    w_state_nxt = c_IDLE;
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_clr_we = 1'b0;
        if (r_state == c_CLEAR) begin
            w_busy   = 1'b1;
            w_clr_we = 1'b1;
        end
    end

    assign busy = w_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if (w_clr_we) begin
            r_idx <= r_idx + A'(1);
        end else begin
            r_idx <= '0;
        end
    end

    // A clear request in the same cycle as a write pulse takes priority.
    assign w_wr_ok = w_we_p && (r_state == c_IDLE) && !w_clr_p &&
                     !((ZERO_REG != 0) && (w_addr_rd == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_bank[r_idx] <= '0;
        end else if (w_wr_ok) begin
            r_bank[w_addr_rd] <= w_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_cnt <= '0;
        end else if (w_wr_ok) begin
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
        end
    end

    assign w_rs1 = ((ZERO_REG != 0) && (w_addr_rs1 == '0)) ? '0 : r_bank[w_addr_rs1];
    assign w_rs2 = ((ZERO_REG != 0) && (w_addr_rs2 == '0)) ? '0 : r_bank[w_addr_rs2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led <= '0;
        end else if (w_tick) begin
            r_led <= {w_rs1, w_rs2, r_wr_cnt};
        end
    end

    assign led = r_led;

endmodule

`default_nettype wire

// File: tb/tb_regbank_board_ctrl.sv
// ============================================================================
// Module   : tb_regbank_board_ctrl
// Brief    : Directed self-checking bench for regbank_board_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regbank_board_ctrl;

    localparam int W         = 4;
    localparam int A         = 2;
    localparam int DIV_COUNT = 4;
    localparam int DB_CYCLES = 3;
    localparam int CNT_W     = 4;
    localparam int ZERO_REG  = 1;

    logic                 clk     = 1'b0;
    logic                 rst     = 1'b0;
    logic                 btn_we  = 1'b0;
    logic                 btn_clr = 1'b0;
    logic [A-1:0]         s_rs1   = '0;
    logic [A-1:0]         s_rs2   = '0;
    logic [A-1:0]         s_rd    = '0;
    logic [W-1:0]         s_data  = '0;
    logic [3*A+W-1:0]     sw;
    logic [2*W+CNT_W-1:0] led;
    logic                 busy;
    logic                 tick;

    int checks   = 0;
    int failures = 0;

    assign sw = {s_rs1, s_rs2, s_rd, s_data};

    always #5 clk = ~clk;

    regbank_board_ctrl #(
        .W         (W),
        .A         (A),
        .DIV_COUNT (DIV_COUNT),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W),
        .ZERO_REG  (ZERO_REG)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .btn_we  (btn_we),
        .btn_clr (btn_clr),
        .led     (led),
        .busy    (busy),
        .tick    (tick)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Selects read addresses and waits until the next tick has loaded led.
    task automatic refresh(input logic [A-1:0] a1, input logic [A-1:0] a2);
        int guard;
        guard = 0;
        s_rs1 = a1;
        s_rs2 = a2;
        while (tick !== 1'b1 && guard < 10) begin
            step(1);
            guard++;
        end
        if (tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL refresh_timeout tick=%b required=1", tick);
        end
        step(1);
    endtask

    task automatic press_we(input logic [A-1:0] rd, input logic [W-1:0] d);
        s_rd   = rd;
        s_data = d;
        btn_we = 1'b1;
        step(5);
        btn_we = 1'b0;
        step(8);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(2);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy busy=%b required=0", busy);
        end
        checks++;
        if (led !== 12'h000) begin
            failures++;
            $display("FAIL reset_led led=%h required=000", led);
        end
        rst = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            checks++;
            if (tick !== (((k + 1) % 4) == 0)) begin
                failures++;
                $display("FAIL tick_cycle%0d tick=%b required=%b", k + 1, tick, (((k + 1) % 4) == 0));
            end
            step(1);
        end
        refresh(2'd0, 2'd1);
        checks++;
        if (led !== 12'h000) begin
            failures++;
            $display("FAIL reset_regs01 led=%h required=000", led);
        end
        refresh(2'd2, 2'd3);
        checks++;
        if (led !== 12'h000) begin
            failures++;
            $display("FAIL reset_regs23 led=%h required=000", led);
        end
    endtask

    task automatic test_bounce();
        s_rd   = 2'd2;
        s_data = 4'hA;
        btn_we = 1'b1;
        step(2);
        btn_we = 1'b0;
        step(1);
        btn_we = 1'b1;
        step(7);
        btn_we = 1'b0;
        step(8);
        refresh(2'd2, 2'd0);
        checks++;
        if (led !== 12'hA01) begin
            failures++;
            $display("FAIL bounce_write led=%h required=A01", led);
        end
    endtask

    task automatic test_zero_reg();
        press_we(2'd0, 4'h5);
        refresh(2'd0, 2'd2);
        checks++;
        if (led !== 12'h0A1) begin
            failures++;
            $display("FAIL zero_reg led=%h required=0A1", led);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        press_we(2'd1, 4'h3);
        press_we(2'd2, 4'h6);
        press_we(2'd3, 4'h9);
        refresh(2'd1, 2'd2);
        checks++;
        if (led !== 12'h364) begin
            failures++;
            $display("FAIL fill_regs12 led=%h required=364", led);
        end
        refresh(2'd3, 2'd0);
        checks++;
        if (led !== 12'h904) begin
            failures++;
            $display("FAIL fill_reg3 led=%h required=904", led);
        end
        // Write pulse lands two cycles after the clear pulse, inside busy.
        s_rd     = 2'd1;
        s_data   = 4'hF;
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 0) btn_clr = 1'b1;
            if (i == 2) btn_we = 1'b1;
            if (i == 7) btn_clr = 1'b0;
            if (i == 9) btn_we = 1'b0;
            step(1);
            if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 4) begin
            failures++;
            $display("FAIL clear_busy_len cycles=%0d required=4", busy_cnt);
        end
        refresh(2'd1, 2'd2);
        checks++;
        if (led !== 12'h004) begin
            failures++;
            $display("FAIL clear_regs12 led=%h required=004", led);
        end
        refresh(2'd3, 2'd0);
        checks++;
        if (led !== 12'h004) begin
            failures++;
            $display("FAIL clear_reg3 led=%h required=004", led);
        end
    endtask

    task automatic test_simultaneous();
        int busy_cnt;
        press_we(2'd3, 4'h7);
        refresh(2'd3, 2'd0);
        checks++;
        if (led !== 12'h705) begin
            failures++;
            $display("FAIL simul_pre led=%h required=705", led);
        end
        s_rd     = 2'd2;
        s_data   = 4'hC;
        busy_cnt = 0;
        btn_we   = 1'b1;
        btn_clr  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                btn_we  = 1'b0;
                btn_clr = 1'b0;
            end
            step(1);
            if (busy === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 4) begin
            failures++;
            $display("FAIL simul_busy_len cycles=%0d required=4", busy_cnt);
        end
        refresh(2'd2, 2'd3);
        checks++;
        if (led !== 12'h005) begin
            failures++;
            $display("FAIL simul_write_lost led=%h required=005", led);
        end
    endtask

    task automatic test_reset_mid_clear();
        int guard;
        press_we(2'd1, 4'h3);
        press_we(2'd3, 4'h9);
        refresh(2'd3, 2'd1);
        checks++;
        if (led !== 12'h937) begin
            failures++;
            $display("FAIL midclr_pre led=%h required=937", led);
        end
        btn_clr = 1'b1;
        guard   = 0;
        while (busy !== 1'b1 && guard < 20) begin
            if (guard == 4) btn_clr = 1'b0;
            step(1);
            guard++;
        end
        btn_clr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midclr_busy_timeout busy=%b required=1", busy);
        end
        step(2);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL midclr_reset_busy busy=%b required=0", busy);
        end
        checks++;
        if (led !== 12'h000) begin
            failures++;
            $display("FAIL midclr_reset_led led=%h required=000", led);
        end
        step(1);
        rst = 1'b1;
        press_we(2'd2, 4'h5);
        refresh(2'd2, 2'd3);
        checks++;
        if (led !== 12'h501) begin
            failures++;
            $display("FAIL midclr_after led=%h required=501", led);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            press_we(A'(1 + (i % 3)), W'(i + 1));
            if (i == 15) begin
                refresh(2'd1, 2'd2);
                checks++;
                if (led !== 12'h0E0) begin
                    failures++;
                    $display("FAIL wrap_16 led=%h required=0E0", led);
                end
            end
        end
        refresh(2'd2, 2'd3);
        checks++;
        if (led !== 12'h1F1) begin
            failures++;
            $display("FAIL wrap_17 led=%h required=1F1", led);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_zero_reg();
        test_clear();
        test_simultaneous();
        test_reset_mid_clear();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog time=%0t required=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
